astar_map_arbiter: RTL and testbench
====================================

# astar_map_arbiter

Arbiter and sequencer for the shared single-port grid-map RAM of the A* path-finding design. After reset it clears the whole 40x40 map to FREE. It then grants one access per cycle to one of two requesters: the A* search engine (read/write) and the display scanner that drives `draw_grid`, `draw_obstacle`, `draw_path` and `draw_unknown` (read-only). It also converts (x,y) cell coordinates to linear RAM addresses and rejects out-of-range coordinates.

## Interface
- GRID_W, 40, map columns
- GRID_H, 40, map rows
- COORD_W, 6, coordinate width
- ADDR_W, 11, RAM address width
- STARVE_MAX, 4, consecutive search losses before search gets forced priority
- sync  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low reset
- clear  in  1  one-cycle pulse; re-run the map clear
- s_req / s_we  in  1 / 1  search request / write enable
- s_x, s_y  in  COORD_W  search cell coordinate
- s_wdata  in  2  cell value to write
- s_gnt  out  1  search request accepted this cycle
- s_rvalid / s_rdata  out  1 / 2  search read return
- d_req  in  1  display read request
- d_x, d_y  in  COORD_W  display cell coordinate
- d_gnt  out  1  display request accepted
- d_rvalid / d_rdata  out  1 / 2  display read return
- m_en / m_we  out  1 / 1  RAM enable / write enable
- m_addr  out  ADDR_W  RAM address
- m_wdata  out  2  RAM write data
- m_rdata  in  2  RAM read data; valid one cycle after the read enable
- init_done  out  1  map clear complete
- bad_coord  out  1  one-cycle pulse for an out-of-range request

## Operation
- Cell encoding: 00 FREE, 01 OBSTACLE, 10 PATH, 11 UNKNOWN.
- States: INIT and ARB.
- INIT behaviour:
  - Writes FREE to address `cnt`, with m_en=1 and m_we=1.
  - `cnt` runs 0 to 1599.
  - No grants are issued.
  - When `cnt`=1599, the next state is ARB.
- ARB, grant selection:
  - At most one grant per cycle; grants are combinational from req and state.
  - Default priority: display wins (real-time).
  - If search starve count ≥ STARVE_MAX and s_req=1, search wins.
  - A lone requester always wins.
- ARB, starve counter:
  - Increments, saturating at STARVE_MAX, on each cycle with s_req=1 and s_gnt=0.
  - Clears on s_gnt=1.
- Requesters hold req, coordinate and data stable until gnt.
- Address: y*40+x, computed as (y<<5)+(y<<3)+x in ADDR_W bits. Maximum is 1599.
- Out-of-range (x≥GRID_W or y≥GRID_H):
  - The request is still granted and consumed, but m_en stays 0.
  - bad_coord pulses the next cycle.
  - A read returns rvalid with rdata=01 (OBSTACLE), so the search treats the cell as a wall.
  - A write is dropped.
- Writes produce no rvalid.
- clear=1 in ARB: no grant that cycle, and the next state is INIT with cnt=0 and init_done=0. clear=1 in INIT restarts cnt at 0.
- A read already granted when clear arrives still returns its rvalid.

## Timing
- During reset=0 (sampled at the edge), all outputs are 0 and state goes to INIT with cnt=0, starve=0. Holds mid-INIT and mid-transaction; any outstanding rvalid is dropped.
- The first clear write occurs in the first cycle after reset is released. The clear takes 1600 cycles.
- init_done is registered and rises in the first ARB cycle.
- Read latency: rvalid and rdata are registered and appear exactly 1 cycle after the gnt cycle. Back-to-back grants give back-to-back rvalids.
- rdata holds its value while rvalid=0.
- Simultaneous s_req and d_req with starve < STARVE_MAX: d_gnt=1, s_gnt=0.

## Structure
- Shared package `astar_pkg` holds:
  - cell encoding constants (CELL_FREE, CELL_OBSTACLE, CELL_PATH, CELL_UNKNOWN);
  - GRID_W, GRID_H, COORD_W, ADDR_W;
  - state encodings for INIT and ARB.
- Sub-module `astar_map_addr`: combinational coordinate-to-address conversion plus range flag. Instantiated twice, once per requester.
- The top level holds the FSM, the starve counter and the return pipeline.

## Test plan
- Reset release: m_en=1, m_we=1 for 1600 consecutive cycles covering addresses 0..1599 with wdata 00. init_done rises on cycle 1601. No gnt during the clear.
- Search write (x=5, y=3, data 01), then read of the same cell: m_addr=125 on both. s_rvalid=1 with s_rdata=01 one cycle after the read gnt.
- Both requesters held continuously: the grant pattern is d,d,d,d,s repeating, and the search never waits more than 4 cycles.
- Display read at (39,39) gives m_addr=1599. Search read at (40,0) gives m_en=0, bad_coord=1 the next cycle, and s_rvalid=1 with s_rdata=01.
- clear pulse mid-ARB with both req high: no gnt that cycle; INIT restarts from addr 0; init_done=0 until 1600 cycles later.
- reset=0 asserted at INIT cnt=800 and held for one cycle: the next clear starts at addr 0, and all outputs are 0 during the reset cycle.

Source files
------------

// File: rtl/astar_pkg.sv
// Shared definitions for the A* grid-map blocks.
// Holds the map geometry, the 2-bit cell encoding and the map arbiter's
// state type.
package astar_pkg;

  localparam int unsigned GRID_W  = 40;
  localparam int unsigned GRID_H  = 40;
  localparam int unsigned COORD_W = 6;
  localparam int unsigned ADDR_W  = 11;

  localparam logic [1:0] CELL_FREE     = 2'b00;
  localparam logic [1:0] CELL_OBSTACLE = 2'b01;
  localparam logic [1:0] CELL_PATH     = 2'b10;
  localparam logic [1:0] CELL_UNKNOWN  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

endpackage

// File: rtl/astar_map_addr.sv
// Combinational (x,y) -> linear map address conversion with range flag.
// Ports:
//   i_x, i_y  : cell coordinate
//   o_addr    : y*40 + x
//   o_bad     : coordinate lies outside the GRID_W x GRID_H map
module astar_map_addr #(
  parameter int unsigned GRID_W  = astar_pkg::GRID_W,
  parameter int unsigned GRID_H  = astar_pkg::GRID_H,
  parameter int unsigned COORD_W = astar_pkg::COORD_W,
  parameter int unsigned ADDR_W  = astar_pkg::ADDR_W
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_bad
);

  // y*40 expressed as y*32 + y*8 to keep it to two adders.
  assign o_addr = (ADDR_W'(i_y) << 5) + (ADDR_W'(i_y) << 3) + ADDR_W'(i_x);
  assign o_bad  = (i_x >= COORD_W'(GRID_W)) || (i_y >= COORD_W'(GRID_H));

endmodule

// File: rtl/astar_map_arbiter.sv
// Arbiter/sequencer for the shared single-port grid-map RAM.
// After reset (or a clear pulse) it writes FREE to every cell, then grants
// one access per cycle to either the search engine (read/write) or the
// display scanner (read-only). Display has priority unless search has lost
// STARVE_MAX times in a row.
// Ports:
//   sync, reset      : clock, synchronous active-low reset
//   clear            : restart the map clear
//   s_*              : search request/grant/read return
//   d_*              : display request/grant/read return
//   m_*              : RAM port (read data valid one cycle after enable)
//   init_done        : map clear finished
//   bad_coord        : pulse after an out-of-range request was consumed
module astar_map_arbiter #(
  parameter int unsigned GRID_W     = astar_pkg::GRID_W,
  parameter int unsigned GRID_H     = astar_pkg::GRID_H,
  parameter int unsigned COORD_W    = astar_pkg::COORD_W,
  parameter int unsigned ADDR_W     = astar_pkg::ADDR_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               sync,
  input  logic               reset,
  input  logic               clear,
  input  logic               s_req,
  input  logic               s_we,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  input  logic [1:0]         s_wdata,
  output logic               s_gnt,
  output logic               s_rvalid,
  output logic [1:0]         s_rdata,
  input  logic               d_req,
  input  logic [COORD_W-1:0] d_x,
  input  logic [COORD_W-1:0] d_y,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [1:0]         d_rdata,
  output logic               m_en,
  output logic               m_we,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [1:0]         m_wdata,
  input  logic [1:0]         m_rdata,
  output logic               init_done,
  output logic               bad_coord
);

  import astar_pkg::*;

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(GRID_W * GRID_H - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [SW-1:0]     r_starve;
  logic              r_init_done, r_bad;
  logic              r_s_pend, r_s_oob, r_d_pend, r_d_oob;
  logic [1:0]        r_s_hold, r_d_hold;

  logic [ADDR_W-1:0] w_s_addr, w_d_addr, w_m_addr;
  logic              w_s_oob, w_d_oob;
  logic              w_s_gnt, w_d_gnt, w_m_en, w_m_we;
  logic [1:0]        w_m_wdata, w_s_ret, w_d_ret;

  astar_map_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W), .ADDR_W(ADDR_W))
    u_s_addr (.i_x(s_x), .i_y(s_y), .o_addr(w_s_addr), .o_bad(w_s_oob));

  astar_map_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W), .ADDR_W(ADDR_W))
    u_d_addr (.i_x(d_x), .i_y(d_y), .o_addr(w_d_addr), .o_bad(w_d_oob));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_m_en      = 1'b0;
    w_m_we      = 1'b0;
    w_m_addr    = '0;
    w_m_wdata   = CELL_FREE;
    unique case (r_state)
      ST_INIT: begin
        w_m_en   = 1'b1;
        w_m_we   = 1'b1;
        w_m_addr = r_cnt;
        if (clear) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST_CELL) begin
          w_state_nxt = ST_ARB;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_ARB: begin
        if (clear) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end else if (s_req && (!d_req || (r_starve >= SW'(STARVE_MAX)))) begin
          // Out-of-range requests are consumed without touching the RAM.
          w_s_gnt   = 1'b1;
          w_m_en    = !w_s_oob;
          w_m_we    = s_we && !w_s_oob;
          w_m_addr  = w_s_addr;
          w_m_wdata = s_wdata;
        end else if (d_req) begin
          w_d_gnt  = 1'b1;
          w_m_en   = !w_d_oob;
          w_m_addr = w_d_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sync) begin
    if (!reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_init_done <= 1'b0;
      r_bad       <= 1'b0;
      r_s_pend    <= 1'b0;
      r_s_oob     <= 1'b0;
      r_s_hold    <= '0;
      r_d_pend    <= 1'b0;
      r_d_oob     <= 1'b0;
      r_d_hold    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_ARB);
      if (w_s_gnt)
        r_starve <= '0;
      else if ((r_state == ST_ARB) && s_req && (r_starve < SW'(STARVE_MAX)))
        r_starve <= r_starve + SW'(1);
      r_bad    <= (w_s_gnt && w_s_oob) || (w_d_gnt && w_d_oob);
      r_s_pend <= w_s_gnt && !s_we;
      r_s_oob  <= w_s_oob;
      r_d_pend <= w_d_gnt;
      r_d_oob  <= w_d_oob;
      if (r_s_pend) r_s_hold <= w_s_ret;
      if (r_d_pend) r_d_hold <= w_d_ret;
    end
  end

  // RAM data arrives in the cycle after the grant, so the return path
  // muxes it straight through and keeps a copy to hold between returns.
  assign w_s_ret = r_s_oob ? CELL_OBSTACLE : m_rdata;
  assign w_d_ret = r_d_oob ? CELL_OBSTACLE : m_rdata;

  assign s_gnt     = reset && w_s_gnt;
  assign d_gnt     = reset && w_d_gnt;
  assign m_en      = reset && w_m_en;
  assign m_we      = reset && w_m_we;
  assign m_addr    = reset ? w_m_addr : '0;
  assign m_wdata   = reset ? w_m_wdata : '0;
  assign s_rvalid  = reset && r_s_pend;
  assign d_rvalid  = reset && r_d_pend;
  assign s_rdata   = !reset ? '0 : (r_s_pend ? w_s_ret : r_s_hold);
  assign d_rdata   = !reset ? '0 : (r_d_pend ? w_d_ret : r_d_hold);
  assign init_done = reset && r_init_done;
  assign bad_coord = reset && r_bad;

endmodule

// File: tb/tb_astar_map_arbiter.sv
module tb_astar_map_arbiter;

  logic       sync = 1'b0;
  logic       reset = 1'b0, clear = 1'b0;
  logic       s_req = 1'b0, s_we = 1'b0, d_req = 1'b0;
  logic [5:0] s_x = '0, s_y = '0, d_x = '0, d_y = '0;
  logic [1:0] s_wdata = '0;
  logic       s_gnt, s_rvalid, d_gnt, d_rvalid, m_en, m_we, init_done, bad_coord;
  logic [1:0] s_rdata, d_rdata, m_wdata, m_rdata;
  logic [10:0] m_addr;

  always #5 sync = ~sync;

  astar_map_arbiter #(.GRID_W(40), .GRID_H(40), .COORD_W(6), .ADDR_W(11), .STARVE_MAX(4)) dut (
    .sync(sync), .reset(reset), .clear(clear),
    .s_req(s_req), .s_we(s_we), .s_x(s_x), .s_y(s_y), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .d_req(d_req), .d_x(d_x), .d_y(d_y), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .init_done(init_done), .bad_coord(bad_coord));

  // Single-port RAM with one-cycle read latency.
  logic [1:0] ram [0:1599];
  logic [1:0] ram_q = 2'b00;
  initial for (int i = 0; i < 1600; i++) ram[i] = 2'b11;
  always @(posedge sync) begin
    if (m_en && (int'(m_addr) < 1600)) begin
      if (m_we) ram[int'(m_addr)] <= m_wdata;
      else      ram_q <= ram[int'(m_addr)];
    end
  end
  assign m_rdata = ram_q;

  int n_cmp = 0, n_bad = 0;
  int phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: map contents, clear progress and search wait count.
  logic [1:0] gold [0:1599];
  bit         md_init = 1'b1, md_done = 1'b0;
  int         md_idx = 0, md_wait = 0;
  bit         e_sv = 1'b0, e_dv = 1'b0, e_bad = 1'b0;
  logic [1:0] e_sd = '0, e_dd = '0;
  initial for (int i = 0; i < 1600; i++) gold[i] = 2'b11;

  // Literal trackers.
  int cyc = 0, pat_k = 0;
  bit prev_done = 1'b0, prev_rst = 1'b0, lit_rd53 = 1'b0, lit_oob = 1'b0;

  always @(negedge sync) begin : cmp
    bit sg, dg, s_oob, d_oob, xen, xwe;
    int s_a, d_a, xaddr;
    logic [1:0] xwd;
    s_oob = (int'(s_x) >= 40) || (int'(s_y) >= 40);
    d_oob = (int'(d_x) >= 40) || (int'(d_y) >= 40);
    s_a = int'(s_y) * 40 + int'(s_x);
    d_a = int'(d_y) * 40 + int'(d_x);
    sg = 0; dg = 0; xen = 0; xwe = 0; xaddr = 0; xwd = 2'b00;
    if (reset) begin
      if (md_init) begin
        xen = 1; xwe = 1; xaddr = md_idx;
      end else if (!clear) begin
        if (s_req && (!d_req || md_wait >= 4)) begin
          sg = 1; xen = !s_oob; xwe = s_we && !s_oob; xaddr = s_a; xwd = s_wdata;
        end else if (d_req) begin
          dg = 1; xen = !d_oob; xaddr = d_a;
        end
      end
    end

    // Hand-computed pins.
    cyc = reset ? cyc + 1 : 0;
    if (phase == 1 && cyc == 1) chk("first_clear_addr", 32'(m_addr), 0);
    if (phase == 1 && init_done && !prev_done) chk("init_rise_cycle", 32'(cyc), 1601);
    if (s_gnt && s_x == 6'd5 && s_y == 6'd3) chk("addr_5_3", 32'(m_addr), 125);
    if (d_gnt && d_x == 6'd39 && d_y == 6'd39) chk("addr_39_39", 32'(m_addr), 1599);
    if (s_gnt && s_x == 6'd40 && s_y == 6'd0) chk("oob_men", 32'(m_en), 0);
    if (lit_rd53) begin
      chk("rd53_rvalid", 32'(s_rvalid), 1);
      chk("rd53_rdata", 32'(s_rdata), 1);
    end
    if (lit_oob) begin
      chk("oob_bad_coord", 32'(bad_coord), 1);
      chk("oob_rvalid", 32'(s_rvalid), 1);
      chk("oob_rdata", 32'(s_rdata), 1);
    end
    if (phase == 3 && (s_gnt || d_gnt)) begin
      chk("grant_pattern", 32'(s_gnt), 32'((pat_k % 5) == 4));
      pat_k++;
    end
    if (phase == 4 && clear && s_req && d_req) chk("clear_nogrant", 32'(s_gnt | d_gnt), 0);
    if (!reset)
      chk("rst_outputs", 32'({s_gnt, s_rvalid, s_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we,
                             m_addr, m_wdata, init_done, bad_coord}), 0);
    if (phase == 5 && reset && !prev_rst) begin
      chk("restart_en", 32'(m_en), 1);
      chk("restart_addr", 32'(m_addr), 0);
    end
    lit_rd53  = (phase == 2) && s_gnt && !s_we && s_x == 6'd5 && s_y == 6'd3;
    lit_oob   = s_gnt && !s_we && s_x == 6'd40 && s_y == 6'd0;
    prev_done = init_done;
    prev_rst  = reset;

    // Model comparison every cycle.
    chk("s_gnt", 32'(s_gnt), 32'(sg));
    chk("d_gnt", 32'(d_gnt), 32'(dg));
    chk("m_en", 32'(m_en), 32'(xen));
    chk("m_we", 32'(m_we), 32'(xwe));
    if (xen) chk("m_addr", 32'(m_addr), 32'(xaddr));
    if (xen && xwe) chk("m_wdata", 32'(m_wdata), 32'(xwd));
    chk("init_done", 32'(init_done), 32'(reset && md_done));
    chk("bad_coord", 32'(bad_coord), 32'(reset && e_bad));
    chk("s_rvalid", 32'(s_rvalid), 32'(reset && e_sv));
    chk("s_rdata", 32'(s_rdata), reset ? 32'(e_sd) : 0);
    chk("d_rvalid", 32'(d_rvalid), 32'(reset && e_dv));
    chk("d_rdata", 32'(d_rdata), reset ? 32'(e_dd) : 0);

    // Advance the model across the coming rising edge.
    if (!reset) begin
      md_init = 1; md_idx = 0; md_wait = 0; md_done = 0;
      e_sv = 0; e_dv = 0; e_bad = 0; e_sd = '0; e_dd = '0;
    end else begin
      e_sv  = sg && !s_we;
      if (e_sv) e_sd = s_oob ? 2'b01 : gold[s_a];
      e_dv  = dg;
      if (e_dv) e_dd = d_oob ? 2'b01 : gold[d_a];
      e_bad = (sg && s_oob) || (dg && d_oob);
      if (sg && s_we && !s_oob) gold[s_a] = s_wdata;
      if (md_init) begin
        gold[md_idx] = 2'b00;
        if (clear) md_idx = 0;
        else if (md_idx == 1599) md_init = 0;
        else md_idx++;
      end else begin
        if (clear) begin md_init = 1; md_idx = 0; end
        if (sg) md_wait = 0;
        else if (s_req && md_wait < 4) md_wait++;
      end
      md_done = !md_init;
    end
  end

  task automatic tick();
    @(posedge sync); #1;
  endtask

  task automatic s_op(input bit we, input logic [5:0] x, input logic [5:0] y, input logic [1:0] wd);
    s_req = 1; s_we = we; s_x = x; s_y = y; s_wdata = wd;
    tick();
    s_req = 0; s_we = 0;
  endtask

  task automatic d_op(input logic [5:0] x, input logic [5:0] y);
    d_req = 1; d_x = x; d_y = y;
    tick();
    d_req = 0;
  endtask

  initial begin
    repeat (3) tick();
    phase = 1; reset = 1;
    repeat (1602) tick();

    phase = 2;
    s_op(1, 6'd5, 6'd3, 2'b01);
    s_op(0, 6'd5, 6'd3, 2'b00);
    tick();
    d_op(6'd5, 6'd3);
    s_op(1, 6'd39, 6'd39, 2'b11);
    d_op(6'd39, 6'd39);
    s_op(0, 6'd40, 6'd0, 2'b00);
    s_op(1, 6'd0, 6'd40, 2'b10);
    d_op(6'd0, 6'd0);
    s_op(0, 6'd39, 6'd39, 2'b00);
    repeat (2) tick();

    phase = 3;
    s_req = 1; s_we = 0; s_x = 6'd1; s_y = 6'd1;
    d_req = 1; d_x = 6'd2; d_y = 6'd2;
    repeat (15) tick();
    s_req = 0; d_req = 0;
    tick();

    phase = 4;
    d_req = 1; d_x = 6'd10; d_y = 6'd10;
    tick();
    s_req = 1; clear = 1;
    tick();
    clear = 0; s_req = 0; d_req = 0;
    repeat (1602) tick();
    d_op(6'd5, 6'd3);
    repeat (2) tick();

    phase = 5;
    clear = 1;
    tick();
    clear = 0;
    repeat (800) tick();
    reset = 0;
    tick();
    reset = 1;
    repeat (1602) tick();
    s_op(0, 6'd39, 6'd39, 2'b00);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
